core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Multi-cycle successor of the single-cycle core top. It sequences fetch, decode, execute, memory and writeback through an FSM, so each core can sit behind a cache with variable-latency req/ready handshakes instead of zero-latency memories. Per-hart parametrisation lets N instances share the multicore cache controller. It owns the PC, the instruction register and all write/retire strobes; the datapath (ALU, register file, immediate generator, branch compare) stays external and combinational.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
HART_ID, 0, core index driven on hart_id and tagged on memory requests
HART_BITS, 2, width of hart_id

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request, held until imem_ready
imem_addr  out  XLEN  fetch address (= pc)
imem_ready  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data request, held until dmem_ready
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  XLEN  data address (registered alu_out)
dmem_ready  in  1  data access complete; dmem_rdata valid this cycle
dmem_rdata  in  XLEN  load data
hart_id  out  HART_BITS  constant HART_ID
instr  out  32  instruction register to the decoder
pc  out  XLEN  current PC
is_load  in  1  decoded load
is_store  in  1  decoded store
is_halt  in  1  decoded ECALL/EBREAK
alu_out  in  XLEN  ALU result, sampled in EXECUTE
br_taken  in  1  branch/jump taken, sampled in EXECUTE
load_data  out  XLEN  registered dmem_rdata for writeback
reg_wr  out  1  one-cycle register-file write strobe in WB
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  core stopped
trap  out  1  sticky misaligned-fetch flag

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH; pc=RESET_PC; instr=32'h0000_0013 (NOP); alu_q, load_data=0; all strobes, halted and trap=0. The first imem_req is asserted in the first cycle after reset deassertion.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready: instr<=imem_rdata, go to DECODE. Otherwise stay; the request and address must not change while waiting.
- DECODE: one cycle so decoder and register-file outputs settle. If is_halt, go to HALT (halted=1, no retire). Otherwise go to EXECUTE.
- EXECUTE: alu_q<=alu_out. next_pc = br_taken ? alu_out : pc+4, modulo 2^XLEN.
  - If br_taken and alu_out[1:0]!=0: trap<=1, go to HALT. pc is unchanged and nothing retires.
  - If is_load or is_store, go to MEM. Otherwise go to WB.
- MEM: dmem_req=1, dmem_we=is_store, dmem_addr=alu_q. Hold until dmem_ready; on a load, load_data<=dmem_rdata. Then go to WB.
- WB: pc<=next_pc (registered in EXECUTE). reg_wr=1 unless is_store or instr[11:7]==0. retire=1. Go to FETCH.
- HALT: absorbing; only reset leaves it. No requests are issued.
- Latency with zero-wait memories: ALU/branch instruction 4 cycles (FETCH, DECODE, EXECUTE, WB); load/store 5 cycles. Each ready-wait cycle adds one.
- imem_ready or dmem_ready outside their request state is ignored.
- Reset asserted mid-request drops the request combinationally; the cache must tolerate the abandoned request.
- pc+4 wraps from 32'hFFFF_FFFC to 0 with no trap.

Optional Feature:
PERF_CNT_EN
- Defined: adds three 64-bit counters, all cleared on reset.
  - cycle_cnt: increments every cycle except in HALT.
  - instret_cnt: increments on retire.
  - stall_cnt: increments each FETCH/MEM cycle where the request is pending and ready=0.
  - Extra outputs: cycle_cnt, instret_cnt, stall_cnt.
- Not defined: counters and their ports are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready tied 1, ADDI x1,x0,5: imem_addr=0 in the first cycle; reg_wr and retire pulse in the 4th cycle; pc=4 afterwards.
- Fetch stall, imem_ready low for 3 cycles: imem_req/imem_addr stay stable for 4 cycles; retire arrives 3 cycles later than the zero-wait case.
- LW with alu_out=0x100, dmem_ready after 2 waits, dmem_rdata=0xDEADBEEF: dmem_addr=0x100 and we=0; load_data=0xDEADBEEF; reg_wr in WB.
- SW, then a JAL with br_taken=1 and alu_out=0x40: store gives dmem_we=1 and no reg_wr; JAL gives pc=0x40 after WB.
- Branch with alu_out=0x42: trap=1, halted=1, pc unchanged, no retire, no further imem_req. Reset clears both flags.
- Reset pulsed during MEM wait: dmem_req drops immediately; after release pc=RESET_PC and state=FETCH. With PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for one hart. It owns PC, IR, the
// registered ALU result, the load-data register and every write/retire strobe.
// Memories are reached through req/ready handshakes, so latency may vary.
// Optional build macro: PERF_CNT_EN adds cycle, retired-instruction and stall
// counters as extra outputs.
module core_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              HART_ID   = 0,
  parameter int              HART_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  input  logic                 dmem_ready,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic [HART_BITS-1:0] hart_id,
  output logic [31:0]          instr,
  output logic [XLEN-1:0]      pc,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 is_halt,
  input  logic [XLEN-1:0]      alu_out,
  input  logic                 br_taken,
  output logic [XLEN-1:0]      load_data,
  output logic                 reg_wr,
  output logic                 retire,
  output logic                 halted,
  output logic                 trap
`ifdef PERF_CNT_EN
  ,
  output logic [63:0]          cycle_cnt,
  output logic [63:0]          instret_cnt,
  output logic [63:0]          stall_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] next_pc_reg;
  logic [XLEN-1:0] alu_q_reg;
  logic [XLEN-1:0] load_data_reg;
  logic [31:0]     instr_reg;
  logic            trap_reg;
  logic            misaligned;

  // A taken branch/jump to a non-word address stops the core instead of retiring.
  assign misaligned = br_taken && (alu_out[1:0] != 2'b00);

  // State register; reset parks the core in FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  // Next-state and handshake/strobe decode. Requests are gated by reset so an
  // in-flight request is dropped the moment reset asserts.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_wr     = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      FETCH: begin
        imem_req = reset;
        if (imem_ready) state_next = DECODE;
      end
      DECODE: begin
        state_next = is_halt ? HALT : EXECUTE;
      end
      EXECUTE: begin
        if (misaligned)              state_next = HALT;
        else if (is_load || is_store) state_next = MEM;
        else                          state_next = WB;
      end
      MEM: begin
        dmem_req = reset;
        dmem_we  = is_store;
        if (dmem_ready) state_next = WB;
      end
      WB: begin
        reg_wr     = !is_store && (instr_reg[11:7] != 5'd0);
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

  // Architectural registers: IR capture, EXECUTE sampling, load capture, PC commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg        <= RESET_PC;
      next_pc_reg   <= RESET_PC;
      instr_reg     <= NOP;
      alu_q_reg     <= '0;
      load_data_reg <= '0;
      trap_reg      <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem_ready) instr_reg <= imem_rdata;
        end
        EXECUTE: begin
          alu_q_reg   <= alu_out;
          next_pc_reg <= br_taken ? alu_out : pc_reg + XLEN'(4);
          if (misaligned) trap_reg <= 1'b1;
        end
        MEM: begin
          if (dmem_ready && !is_store) load_data_reg <= dmem_rdata;
        end
        WB: begin
          pc_reg <= next_pc_reg;
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr = pc_reg;
  assign dmem_addr = alu_q_reg;
  assign pc        = pc_reg;
  assign instr     = instr_reg;
  assign load_data = load_data_reg;
  assign halted    = (state_reg == HALT);
  assign trap      = trap_reg;
  assign hart_id   = HART_BITS'(HART_ID);

`ifdef PERF_CNT_EN
  logic [2:0]  cnt_inc;
  logic [63:0] cnt_reg [3];

  assign cnt_inc[0] = (state_reg != HALT);
  assign cnt_inc[1] = retire;
  assign cnt_inc[2] = ((state_reg == FETCH) && !imem_ready) ||
                      ((state_reg == MEM)   && !dmem_ready);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      // One free-running 64-bit event counter per enable bit.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)           cnt_reg[gi] <= '0;
        else if (cnt_inc[gi]) cnt_reg[gi] <= cnt_reg[gi] + 64'd1;
      end
    end
  endgenerate

  assign cycle_cnt   = cnt_reg[0];
  assign instret_cnt = cnt_reg[1];
  assign stall_cnt   = cnt_reg[2];
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: the bench plays decoder, ALU and both
// memories, stepping the FSM on negedges and checking strobes and registers.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_rdata;
  logic [1:0]  hart_id;
  logic [31:0] instr, pc, alu_out, load_data;
  logic        is_load, is_store, is_halt, br_taken;
  logic        reg_wr, retire, halted, trap;
`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_sequencer #(.XLEN(32), .RESET_PC(32'h0), .HART_ID(1), .HART_BITS(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .hart_id(hart_id), .instr(instr), .pc(pc),
    .is_load(is_load), .is_store(is_store), .is_halt(is_halt), .alu_out(alu_out),
    .br_taken(br_taken), .load_data(load_data), .reg_wr(reg_wr), .retire(retire),
    .halted(halted), .trap(trap)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one fetched instruction together with its decoded controls.
  task automatic set_instr(input logic [31:0] word, input logic [31:0] alu,
                           input logic brt, input logic ld, input logic st, input logic hlt);
    imem_rdata = word;
    alu_out    = alu;
    br_taken   = brt;
    is_load    = ld;
    is_store   = st;
    is_halt    = hlt;
    imem_ready = 1'b1;
  endtask

  // Step negedges until retire is seen, bounded.
  task automatic wait_retire(output int n);
    n = 0;
    while (retire !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("retire_seen", {63'd0, retire}, 64'd1);
  endtask

  int          n;
  logic        bad;
`ifdef PERF_CNT_EN
  logic [63:0] cyc_snap;
`endif

  initial begin
    reset = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0;
    alu_out = 32'h0; br_taken = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_strobes", {retire, reg_wr, halted, trap}, 0);
    chk("rst_load_data", load_data, 0);
    chk("hart_id", hart_id, 1);
`ifdef PERF_CNT_EN
    chk("rst_cnt", cycle_cnt | instret_cnt | stall_cnt, 0);
`endif

    // ADDI x1,x0,5 with zero-wait fetch
    reset = 1'b1;
    set_instr(32'h0050_0093, 32'd5, 0, 0, 0, 0);
    #1;
    chk("addi_c1_req", imem_req, 1);
    chk("addi_c1_addr", imem_addr, 0);
    @(negedge clk);
    chk("addi_c2_instr", instr, 32'h0050_0093);
    chk("addi_c2_req", imem_req, 0);
    @(negedge clk);
    chk("addi_c3_retire", retire, 0);
    @(negedge clk);
    chk("addi_c4_retire", retire, 1);
    chk("addi_c4_reg_wr", reg_wr, 1);
    chk("addi_c4_pc", pc, 0);
    @(negedge clk);
    chk("addi_pc_after", pc, 4);
    chk("addi_retire_once", retire, 0);
`ifdef PERF_CNT_EN
    chk("addi_cycle_cnt", cycle_cnt, 4);
    chk("addi_instret", instret_cnt, 1);
`endif

    // Fetch stall: three wait cycles, request/address held
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 4);
      @(negedge clk);
    end
    chk("stall_req_c4", imem_req, 1);
    chk("stall_addr_c4", imem_addr, 4);
    set_instr(32'h0070_0113, 32'd7, 0, 0, 0, 0);
    wait_retire(n);
    chk("stall_fetch_to_retire", n, 3);
    chk("stall_pc_in_wb", pc, 4);
    @(negedge clk);
    chk("stall_pc_after", pc, 8);
`ifdef PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 3);
`endif

    // LW x3: alu_out=0x100, two dmem waits
    set_instr(32'h0000_2183, 32'h100, 0, 1, 0, 0);
    dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    alu_out = 32'h999;
    #1;
    chk("lw_dmem_req", dmem_req, 1);
    chk("lw_dmem_addr", dmem_addr, 32'h100);
    chk("lw_dmem_we", dmem_we, 0);
    @(negedge clk);
    chk("lw_wait2_req", dmem_req, 1);
    @(negedge clk);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    chk("lw_load_data", load_data, 32'hDEAD_BEEF);
    chk("lw_reg_wr", reg_wr, 1);
    chk("lw_retire", retire, 1);
    @(negedge clk);
    chk("lw_pc_after", pc, 12);

    // SW x2,4(x1): store, rd field non-zero but no register write
    set_instr(32'h0020_A223, 32'h200, 0, 0, 1, 0);
    dmem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("sw_dmem_we", dmem_we, 1);
    chk("sw_dmem_req", dmem_req, 1);
    chk("sw_dmem_addr", dmem_addr, 32'h200);
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("sw_retire", retire, 1);
    chk("sw_reg_wr", reg_wr, 0);
    @(negedge clk);
    chk("sw_pc_after", pc, 16);

    // JAL x1 to 0x40
    set_instr(32'h0300_00EF, 32'h40, 1, 0, 0, 0);
    wait_retire(n);
    chk("jal_reg_wr", reg_wr, 1);
    @(negedge clk);
    chk("jal_pc", pc, 32'h40);

    // Jump to top of address space with rd=x0, then wrap pc+4 to 0
    set_instr(32'h0000_006F, 32'hFFFF_FFFC, 1, 0, 0, 0);
    wait_retire(n);
    chk("jx0_reg_wr", reg_wr, 0);
    @(negedge clk);
    chk("top_pc", imem_addr, 32'hFFFF_FFFC);
    set_instr(32'h0050_0093, 32'd5, 0, 0, 0, 0);
    wait_retire(n);
    @(negedge clk);
    chk("wrap_pc", pc, 0);
    chk("wrap_no_trap", trap, 0);

    // Misaligned branch target 0x42 traps
    set_instr(32'h0000_0063, 32'h42, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("trap_flag", trap, 1);
    chk("trap_halted", halted, 1);
    chk("trap_pc", pc, 0);
`ifdef PERF_CNT_EN
    cyc_snap = cycle_cnt;
`endif
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bad = bad | imem_req | dmem_req | retire | reg_wr;
      @(negedge clk);
    end
    chk("halt_quiet", bad, 0);
    chk("halt_sticky", {halted, trap}, 2'b11);
`ifdef PERF_CNT_EN
    chk("halt_cycle_frozen", cycle_cnt, cyc_snap);
`endif
    reset = 1'b0;
    #1;
    chk("trap_reset_clr", {halted, trap}, 0);
    @(negedge clk);
    reset = 1'b1;

    // ECALL halts without retiring and without trap
    set_instr(32'h0000_0073, 32'h0, 0, 0, 0, 1);
    @(negedge clk);
    chk("ecall_decode_retire", retire, 0);
    @(negedge clk);
    chk("ecall_halted", halted, 1);
    chk("ecall_no_trap", trap, 0);
    chk("ecall_no_req", imem_req, 0);

    // Reset during a MEM wait drops dmem_req at once
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    set_instr(32'h0000_2183, 32'h100, 0, 1, 0, 0);
    dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmem_req_before", dmem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rmem_req_dropped", dmem_req, 0);
    chk("rmem_pc", pc, 0);
    chk("rmem_imem_req", imem_req, 0);
`ifdef PERF_CNT_EN
    chk("rmem_cnt_zero", cycle_cnt | instret_cnt | stall_cnt, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rmem_fetch_req", imem_req, 1);
    chk("rmem_fetch_addr", imem_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
